// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_rx_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

    // Width of the per-bit cycle counter; never below one bit.
    function automatic int unsigned cnt_w(input int unsigned clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO; head lives in slot 0, reads as zero when empty.
module byte_fifo2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic [1:0] count_o
);

    logic [1:0][7:0] mem_q, mem_d;
    logic [1:0]      count_q, count_d;
    logic            pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign rdata_o = (count_q == 2'd0) ? 8'h00 : mem_q[0];

    // Next-state: a push into a full FIFO without a pop is silently dropped here.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        case ({push_i, pop_ok})
            2'b10: begin
                if (count_q != 2'd2) begin
                    mem_d[count_q[0]] = wdata_i;
                    count_d           = count_q + 2'd1;
                end
            end
            2'b01: begin
                mem_d[0] = mem_q[1];
                mem_d[1] = 8'h00;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; with one entry the new byte becomes head.
                if (count_q == 2'd2) begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = wdata_i;
                end else begin
                    mem_d[0] = wdata_i;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with glitch rejection, break handling and a 2-byte output FIFO.
module uart_byte_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       clear_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned CntW = cnt_w(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(FRAME_BITS);
    localparam logic [CntW-1:0] CntBitMax  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalfMax = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BitW-1:0] LastBit    = BitW'(FRAME_BITS - 1);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync2_q;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            rxs;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic [1:0]      fifo_count;

    assign rxs = sync2_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    // Receiver next-state: mid-bit sampling driven by a per-bit cycle counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == CntHalfMax) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_d = rxs ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == CntBitMax) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == CntBitMax) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                // Hold here until the line recovers so a break reports only once.
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop = valid_o && ready_i;

    // Sticky overrun; a fresh drop outranks a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (push && fifo_full && !pop) begin
            overrun_d = 1'b1;
        end else if (clear_i) begin
            overrun_d = 1'b0;
        end
    end

    // Receiver and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    byte_fifo2 u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .rdata_o (data_o),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign valid_o     = (fifo_count != 2'd0);
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios plus a randomized frame stream.
module tb_uart_byte_rx;

    localparam int unsigned Clks  = 8;
    localparam int unsigned Depth = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic       clear_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    always #5 clk = ~clk;

    uart_byte_rx #(.CLKS_PER_BIT(Clks)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .clear_i     (clear_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  sent_q[$];
    int unsigned ferr_cnt;
    int unsigned valid_cnt;
    logic        busy_seen;
    logic        rnd_done;

    // Consumer-side observer: records accepted bytes and counts error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_err_o) ferr_cnt++;
            if (valid_o) valid_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame on the line, LSB first; the line keeps the stop level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        tick(Clks);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            tick(Clks);
        end
        rx_i = stop;
        tick(Clks);
    endtask

    task automatic expect_stream(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        ferr_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_data"}, data_o, 0);
        check_eq({tag, "_valid"}, valid_o, 0);
        check_eq({tag, "_ferr"}, frame_err_o, 0);
        check_eq({tag, "_ovr"}, overrun_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        rst     = 1'b1;
        rx_i    = 1'b1;
        clear_i = 1'b0;
        ready_i = 1'b0;
        clear_obs();
        tick(3);
        rst = 1'b0;
        check_idle_outputs("reset");

        // Single frame, consumer always ready.
        clear_obs();
        ready_i = 1'b1;
        send_frame(8'hA5, 1'b1);
        tick(5);
        exp_q.push_back(8'hA5);
        expect_stream("single");
        check_eq("single_valid_cycles", valid_cnt, 1);
        check_eq("single_ferr", ferr_cnt, 0);
        check_eq("single_ovr", overrun_o, 0);

        // Three frames into a stalled consumer: only the first Depth survive.
        clear_obs();
        ready_i = 1'b0;
        sent_q  = '{8'h11, 8'h22, 8'h33};
        foreach (sent_q[i]) send_frame(sent_q[i], 1'b1);
        tick(4);
        for (int i = 0; i < Depth; i++) exp_q.push_back(sent_q[i]);
        check_eq("ovr_set", overrun_o, (sent_q.size() > Depth) ? 1 : 0);
        check_eq("ovr_valid", valid_o, 1);
        check_eq("ovr_head", data_o, exp_q[0]);
        clear_i = 1'b1;
        tick(1);
        clear_i = 1'b0;
        check_eq("ovr_cleared", overrun_o, 0);
        ready_i = 1'b1;
        tick(4);
        expect_stream("ovr");
        check_eq("ovr_drained", valid_o, 0);

        // Bad stop bit followed by a held-low line, then a clean frame.
        clear_obs();
        send_frame(8'h3C, 1'b0);
        tick(40);
        check_eq("break_ferr", ferr_cnt, 1);
        check_eq("break_bytes", got_q.size(), 0);
        check_eq("break_valid_cycles", valid_cnt, 0);
        rx_i = 1'b1;
        tick(Clks);
        send_frame(8'h3C, 1'b1);
        tick(5);
        exp_q.push_back(8'h3C);
        expect_stream("after_break");
        check_eq("after_break_ferr", ferr_cnt, 1);

        // Short low glitch in idle must be rejected quietly.
        clear_obs();
        busy_seen = 1'b0;
        rx_i = 1'b0;
        tick(2);
        rx_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            busy_seen |= busy_o;
        end
        check_eq("glitch_busy_seen", busy_seen, 1);
        check_eq("glitch_busy_fell", busy_o, 0);
        tick(2 * Clks);
        check_eq("glitch_bytes", got_q.size(), 0);
        check_eq("glitch_ferr", ferr_cnt, 0);

        // Full FIFO with a pop landing on the stop-bit sample cycle of a third frame.
        clear_obs();
        ready_i = 1'b0;
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        check_eq("full_head", data_o, 8'h41);
        fork
            send_frame(8'h43, 1'b1);
            begin
                // Stop sample edge: 2 sync + 1 idle + Clks/2 start + 9*Clks bits, minus one.
                tick(3 + Clks / 2 + 9 * Clks - 1);
                ready_i = 1'b1;
                tick(1);
                ready_i = 1'b0;
            end
        join
        tick(2);
        check_eq("simul_ovr", overrun_o, 0);
        ready_i = 1'b1;
        tick(4);
        exp_q = '{8'h41, 8'h42, 8'h43};
        expect_stream("simul");

        // Reset in the middle of a frame with a byte already buffered.
        clear_obs();
        ready_i = 1'b0;
        send_frame(8'h77, 1'b1);
        rx_i = 1'b0;
        tick(Clks);
        rx_i = 1'b1;
        tick(3 * Clks);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_idle_outputs("midrst");
        tick(6 * Clks);
        clear_obs();
        ready_i = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(5);
        exp_q.push_back(8'h5A);
        expect_stream("midrst");

        // Randomized frames and consumer stalls against the frame-level model.
        clear_obs();
        rnd_done = 1'b0;
        begin
            int unsigned exp_ferr;
            exp_ferr = 0;
            fork
                begin
                    for (int f = 0; f < 12; f++) begin
                        logic [7:0] b;
                        logic       good;
                        b    = 8'($urandom_range(0, 255));
                        good = ($urandom_range(0, 4) != 0);
                        send_frame(b, good);
                        if (good) begin
                            exp_q.push_back(b);
                        end else begin
                            exp_ferr++;
                            tick($urandom_range(5, 30));
                            rx_i = 1'b1;
                        end
                        tick(Clks + $urandom_range(0, 5));
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        ready_i = ($urandom_range(0, 3) != 0);
                        tick(1);
                    end
                    ready_i = 1'b1;
                end
            join
            tick(5);
            expect_stream("rnd");
            check_eq("rnd_ferr", ferr_cnt, exp_ferr);
            check_eq("rnd_ovr", overrun_o, 0);
            check_eq("rnd_empty", valid_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
